spram_byte_ram: RTL
===================

Name: spram_byte_ram

Overview:
- Byte-wide CPU RAM built from 1..4 iCE40UP5K SPRAM macros (32 KB each), for the Z80 memory map.
- Adds over the single-macro version:
  - bank decode;
  - a ready handshake;
  - per-bank idle standby with wake-up stall;
  - a registered read-valid strobe;
  - an optional post-reset zero-fill engine.
- Sits between the CPU bus decoder and the SPRAM primitives.

Parameters:
- BANKS, 2: number of SPRAM macros, legal values 1, 2, 4; capacity = BANKS*32 KB.
- IDLE_CYCLES, 1024: consecutive unaccessed cycles before a bank enters STANDBY; 0 disables standby.
- ADDR_W (localparam): 15 + clog2(BANKS).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- sel  in  1  access request
- we  in  1  write when 1, read when 0
- addr  in  ADDR_W  byte address; upper bits select bank, addr[14:1] is the word, addr[0] selects the byte lane
- din  in  8  write data
- ready  out  1  request accepted this cycle when sel & ready
- dout  out  8  read data, valid when rvalid
- rvalid  out  1  one-cycle strobe, cycle after an accepted read
- busy  out  1  zero-fill in progress

Behaviour:
- Reset values: ready=0 while reset is asserted; rvalid=0; dout=0; busy=1 when RAM_CLEAR_EN is defined, else 0; all standby bits 0; idle counters 0.
- Accept: a request is accepted when sel & ready.
  - Accepted write: masked write to bank addr[ADDR_W-1:15]. MASKWREN=1100 if addr[0]=1, else 0011. DATAIN={din,din}.
  - Accepted read: CHIPSELECT to the target bank only. Bank index and addr[0] are registered. Next cycle: dout = selected bank's DATAOUT byte, rvalid=1.
- Read latency is exactly 1 cycle; back-to-back reads give rvalid on consecutive cycles.
- dout holds its last value when rvalid=0, via a registered output mux.
- ready = ~busy & ~(sel & standby[bank(addr)]), combinational.
- Standby / idle:
  - Per-bank counter, clog2(IDLE_CYCLES+1) bits, saturating.
  - Cleared on any accepted access to that bank; increments otherwise.
  - At IDLE_CYCLES the bank's standby bit is set and drives STANDBY.
- Wake:
  - sel to a standby bank: ready=0 that cycle.
  - standby bit clears on the next edge.
  - The following cycle the request is accepted if sel is held.
  - The requester must hold sel/we/addr/din until ready=1.
- Simultaneous events:
  - Wake of one bank does not disturb the other banks' counters.
  - An idle counter reaching the threshold in the same cycle as an access to that bank: the access wins, counter clears, no standby.
- SLEEP=0, POWEROFF=1 on all macros.
- Reset mid-operation:
  - An in-flight read produces no rvalid.
  - Zero-fill restarts from word 0.
  - Write data already clocked into SPRAM stays written; no rollback.
- Address wrap: none. Bank-index bits beyond BANKS-1 cannot occur, because ADDR_W is exact.

Optional Feature:
- RAM_CLEAR_EN defined:
  - After reset, an FSM writes 0x0000 to every word of every bank in parallel (MASKWREN=1111, CHIPSELECT all), then drops busy.
  - FSM states: CLEAR (word counter 0..16383, one word per cycle), DONE.
  - busy=1 for exactly 16384 cycles after reset release.
  - ready=0 and sel is ignored throughout CLEAR.
  - Standby counters are held at 0 during CLEAR.
- RAM_CLEAR_EN undefined:
  - No FSM; busy tied 0; first access can be accepted on the first edge after reset release.
  - Contents are undefined at power-up.

Decomposition:
- Shared include file: SPRAM geometry constants (SPRAM_WORDS=16384, SPRAM_AW=14, BANK_BYTES=32768) and the MASKWREN lane encodings.
- Sub-module spram_bank: one SB_SPRAM256KA plus its SIMULATE behavioural model (16384x16, zero-initialised, 4-bit nibble masks honoured).
- Generate loop instantiates BANKS copies.
- Top level holds bank decode, idle/standby logic, handshake, output pipeline and the clear FSM.

Test Plan:
- Byte lanes, BANKS=2, clear disabled: write 0x5A to 0x0000 and 0xA5 to 0x0001, read both. Required: dout 0x5A then 0xA5, each with rvalid the cycle after accept; the word at 0x0000 reads back as 0xA55A.
- Bank isolation: write 0x11 to 0x7FFF and 0x22 to 0x8000. Required: reads return 0x11 and 0x22; 0x0000 is unchanged.
- Standby/wake, IDLE_CYCLES=8: access bank 0, idle 8 cycles. Required: STANDBY asserted on bank 0. Then read 0x0010: ready=0 for one cycle, accepted the next cycle, correct data.
- RAM_CLEAR_EN: preload 0xFF everywhere, pulse reset. Required: busy high for exactly 16384 cycles; sel is ignored meanwhile; reads of 0x0000, 0x7FFF and 0xFFFF all return 0x00.
- Reset mid-read: assert reset the same cycle a read is accepted. Required: no rvalid; dout=0; ready recovers after release (after the fill when RAM_CLEAR_EN is defined).
- Back-to-back: 16 consecutive accepted reads across both banks. Required: 16 contiguous rvalid pulses, in-order data.

Source files
------------

// File: rtl/spram_byte_ram_pkg.sv
// spram_byte_ram_pkg: shared SPRAM geometry, byte-lane write masks, the bank
// request struct and the zero-fill FSM state type.
package spram_byte_ram_pkg;
   localparam int SPRAM_WORDS = 16384;
   localparam int SPRAM_AW    = 14;
   localparam int BANK_BYTES  = 32768;

   // MASKWREN has one enable bit per nibble of the 16-bit word.
   localparam logic [3:0] MASK_LO  = 4'b0011;
   localparam logic [3:0] MASK_HI  = 4'b1100;
   localparam logic [3:0] MASK_ALL = 4'b1111;

   typedef enum logic {CLR_CLEAR, CLR_DONE} clr_state_t;

   typedef struct packed {
      logic [SPRAM_AW-1:0] addr;
      logic [15:0]         data;
      logic [3:0]          mask;
      logic                we;
   } bank_req_t;
endpackage

// File: rtl/spram_byte_ram_bank.sv
// spram_byte_ram_bank: one 16384x16 SPRAM macro.
//   clk_i  : clock
//   cs_i   : chip select for this bank
//   req_i  : word address, write data, nibble mask, write enable
//   stby_i : low-power standby (no access while high)
//   data_o : registered read data
// Define ICE40_SPRAM to instantiate SB_SPRAM256KA; otherwise a behavioural
// model with the same synchronous-read / nibble-masked-write behaviour is used.
module spram_byte_ram_bank
   import spram_byte_ram_pkg::*;
(
   input  logic        clk_i,
   input  logic        cs_i,
   input  bank_req_t   req_i,
   input  logic        stby_i,
   output logic [15:0] data_o
);
`ifdef ICE40_SPRAM
   SB_SPRAM256KA u_spram (
      .ADDRESS    (req_i.addr),
      .DATAIN     (req_i.data),
      .MASKWREN   (req_i.mask),
      .WREN       (req_i.we),
      .CHIPSELECT (cs_i),
      .CLOCK      (clk_i),
      .STANDBY    (stby_i),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (data_o)
   );
`else
   logic [15:0] mem_q [SPRAM_WORDS];
   logic [15:0] data_q;

   always_ff @(posedge clk_i) begin
      if (cs_i && !stby_i) begin
         if (req_i.we) begin
            for (int n = 0; n < 4; n++)
               if (req_i.mask[n]) mem_q[req_i.addr][n*4 +: 4] <= req_i.data[n*4 +: 4];
         end else begin
            data_q <= mem_q[req_i.addr];
         end
      end
   end

   assign data_o = data_q;
`endif
endmodule

// File: rtl/spram_byte_ram.sv
// spram_byte_ram: byte-wide CPU RAM over BANKS SPRAM macros (32 KB each).
//   clk, reset (async, active high)
//   sel/we/addr/din : request; accepted when sel & ready
//   ready           : combinational accept
//   dout/rvalid     : read data, valid the cycle after an accepted read
//   busy            : zero-fill in progress
// Banks idle for IDLE_CYCLES cycles drop into STANDBY; a request to a sleeping
// bank stalls one cycle while it wakes. Define RAM_CLEAR_EN to zero-fill all
// banks after reset.
module spram_byte_ram
   import spram_byte_ram_pkg::*;
#(
   parameter  int BANKS       = 2,
   parameter  int IDLE_CYCLES = 1024,
   localparam int ADDR_W      = 15 + $clog2(BANKS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sel,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        din,
   output logic              ready,
   output logic [7:0]        dout,
   output logic              rvalid,
   output logic              busy
);
   localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int CW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);

   logic [BW-1:0]       bank;
   logic [BANKS-1:0]    stby;
   logic [15:0]         rdata [BANKS];
   logic                clearing, accept, rd_acc;
   logic [SPRAM_AW-1:0] clr_addr;
   bank_req_t           req;

   if (BANKS > 1) begin : g_dec
      assign bank = addr[ADDR_W-1:15];
   end else begin : g_one
      assign bank = '0;
   end

`ifdef RAM_CLEAR_EN
   clr_state_t          state_q;
   logic [SPRAM_AW-1:0] clr_cnt_q;
   logic                busy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= CLR_CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         case (state_q)
            CLR_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == SPRAM_AW'(SPRAM_WORDS - 1)) begin
                  state_q <= CLR_DONE;
                  busy_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // No SPRAM writes while reset is held; fill starts on the first edge after release.
   assign clearing = (state_q == CLR_CLEAR) && !reset;
   assign clr_addr = clr_cnt_q;
   assign busy     = busy_q;
`else
   assign clearing = 1'b0;
   assign clr_addr = '0;
   assign busy     = 1'b0;
`endif

   assign ready  = !reset && !busy && !(sel && stby[bank]);
   assign accept = sel && ready;
   assign rd_acc = accept && !we;

   // All banks share one request bus; chip select picks the target.
   always_comb begin
      req = '0;
      if (clearing) begin
         req.addr = clr_addr;
         req.data = '0;
         req.mask = MASK_ALL;
         req.we   = 1'b1;
      end else begin
         req.addr = addr[SPRAM_AW:1];
         req.data = {din, din};
         req.mask = addr[0] ? MASK_HI : MASK_LO;
         req.we   = we;
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic hit, cs;
      assign hit = accept && (bank == BW'(b));
      assign cs  = clearing || hit;

      spram_byte_ram_bank u_bank (
         .clk_i  (clk),
         .cs_i   (cs),
         .req_i  (req),
         .stby_i (stby[b]),
         .data_o (rdata[b])
      );

      if (IDLE_CYCLES > 0) begin : g_idle
         logic [CW-1:0] cnt_q, cnt_d;
         logic          stby_q, stby_d, wake;

         assign wake = sel && stby_q && (bank == BW'(b));

         // An access on the threshold cycle wins: counter clears, no standby.
         always_comb begin
            cnt_d  = cnt_q;
            stby_d = stby_q;
            if (clearing || hit || wake) begin
               cnt_d  = '0;
               stby_d = 1'b0;
            end else begin
               if (cnt_q != IDLE_MAX) cnt_d = cnt_q + 1'b1;
               stby_d = (cnt_d == IDLE_MAX);
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_q  <= '0;
               stby_q <= 1'b0;
            end else begin
               cnt_q  <= cnt_d;
               stby_q <= stby_d;
            end
         end

         assign stby[b] = stby_q;
      end else begin : g_no_idle
         assign stby[b] = 1'b0;
      end
   end

   // Read return: SPRAM output is already registered, so the lane mux is
   // combinational while rvalid and falls back to the held byte otherwise.
   logic          rvalid_q, lane_q;
   logic [BW-1:0] bank_q;
   logic [7:0]    dout_q;
   logic [15:0]   rsel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid_q <= 1'b0;
         lane_q   <= 1'b0;
         bank_q   <= '0;
         dout_q   <= '0;
      end else begin
         rvalid_q <= rd_acc;
         dout_q   <= dout;
         if (rd_acc) begin
            bank_q <= bank;
            lane_q <= addr[0];
         end
      end
   end

   assign rsel   = rdata[bank_q];
   assign dout   = rvalid_q ? (lane_q ? rsel[15:8] : rsel[7:0]) : dout_q;
   assign rvalid = rvalid_q;
endmodule
